hd44780_multi_phy: RTL

HD44780_MULTI_PHY -- requirements
Module: hd44780_multi_phy

---
 rtl/hd44780_multi_phy.sv | 305 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hd44780_multi_phy.sv
// HD44780 LCD PHY: queues {RS,RWB,D} instructions in a FIFO and plays them out as timed bus cycles.
// Latency: one pop cycle, then 3 prescaled phases per transfer; instr_ready_o drops while the FIFO is full.

module hd44780_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdat_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdat_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdat_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o && !flush_i;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdat_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end
endmodule

module hd44780_multi_phy #(
    parameter int BUS_WIDTH       = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int NUM_E           = 1,
    parameter int PRESCALER_WIDTH = 16,
    parameter int POLL_MAX        = 1023
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [9:0]                   instr_i,
    input  logic [NUM_E-1:0]             instr_esel_i,
    input  logic                         instr_valid_i,
    output logic                         instr_ready_o,
    input  logic [PRESCALER_WIDTH-1:0]   prescaler_i,
    input  logic                         enable_i,
    input  logic                         poll_en_i,
    input  logic                         flush_i,
    output logic [7:0]                   rdata_o,
    output logic                         rdata_valid_o,
    output logic                         busy_o,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
    output logic                         ovf_o,
    output logic                         err_o,
    input  logic [BUS_WIDTH-1:0]         data_in_i,
    output logic [BUS_WIDTH-1:0]         data_out_o,
    output logic                         data_oe_o,
    output logic                         rs_o,
    output logic                         rwb_o,
    output logic [NUM_E-1:0]             e_o
);
    localparam int PW  = PRESCALER_WIDTH;
    localparam int PCW = $clog2(POLL_MAX + 1);

    typedef struct packed {
        logic             rs;
        logic             rwb;
        logic [7:0]       dat;
        logic [NUM_E-1:0] esel;
    } instr_t;

    typedef enum logic [1:0] {IDLE, SETUP, EHIGH, HOLD} state_t;

    state_t           state_q, state_d;
    instr_t           cur_q, cur_d;
    instr_t           fifo_head, fifo_wdat;
    logic [PW-1:0]    presc_q, presc_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             nib_q, nib_d;
    logic             polling_q, polling_d;
    logic             pollen_q, pollen_d;
    logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
    logic [7:0]       rbuf_q, rbuf_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             fifo_full, fifo_empty, pop;
    logic             active, phase_done, last_nib, err_set;
    logic             rs_act, rwb_act;
    logic [3:0]       nibble;
    logic [7:0]       din8, dout8;
    logic [NUM_E-1:0] emask;

    assign fifo_wdat = {instr_i, instr_esel_i};
    assign pop       = (state_q == IDLE) && enable_i && !fifo_empty && !flush_i;

    hd44780_fifo #(
        .WIDTH ($bits(instr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (instr_valid_i),
        .wdat_i  (fifo_wdat),
        .pop_i   (pop),
        .rdat_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

    // Busy-flag polls reuse the instruction's esel but are always RS=0 reads.
    assign active     = (state_q != IDLE);
    assign rwb_act    = polling_q | cur_q.rwb;
    assign rs_act     = !polling_q & cur_q.rs;
    assign phase_done = (cnt_q == presc_q - PW'(1));
    assign last_nib   = (BUS_WIDTH == 8) || nib_q;
    assign nibble     = nib_q ? cur_q.dat[3:0] : cur_q.dat[7:4];
    assign emask      = rwb_act ? (cur_q.esel & (~cur_q.esel + NUM_E'(1))) : cur_q.esel;

    always_comb begin
        din8                 = '0;
        din8[BUS_WIDTH-1:0]  = data_in_i;
        dout8                = '0;
        if (active && !rwb_act) begin
            dout8 = (BUS_WIDTH == 8) ? cur_q.dat : {4'h0, nibble};
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        presc_d       = presc_q;
        cnt_d         = cnt_q;
        nib_d         = nib_q;
        polling_d     = polling_q;
        pollen_d      = pollen_q;
        poll_cnt_d    = poll_cnt_q;
        rbuf_d        = rbuf_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_set       = 1'b0;
        ovf_d         = instr_valid_i && fifo_full && !flush_i;

        if (active) begin
            cnt_d = phase_done ? '0 : cnt_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_d      = fifo_head;
                    presc_d    = (prescaler_i == '0) ? PW'(1) : prescaler_i;
                    cnt_d      = '0;
                    nib_d      = 1'b0;
                    polling_d  = 1'b0;
                    poll_cnt_d = '0;
                    pollen_d   = poll_en_i && !fifo_head.rwb;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (phase_done) state_d = EHIGH;
            end
            EHIGH: begin
                if (phase_done) begin
                    state_d = HOLD;
                    if (rwb_act) begin
                        if (BUS_WIDTH == 8)  rbuf_d      = din8;
                        else if (!nib_q)     rbuf_d[7:4] = din8[3:0];
                        else                 rbuf_d[3:0] = din8[3:0];
                    end
                end
            end
            HOLD: begin
                if (phase_done) begin
                    if (!last_nib) begin
                        nib_d   = 1'b1;
                        state_d = SETUP;
                    end else begin
                        nib_d = 1'b0;
                        if (polling_q) begin
                            if (!rbuf_q[7]) begin
                                polling_d = 1'b0;
                                state_d   = IDLE;
                            end else if (poll_cnt_q == PCW'(POLL_MAX - 1)) begin
                                polling_d = 1'b0;
                                err_set   = 1'b1;
                                state_d   = IDLE;
                            end else begin
                                poll_cnt_d = poll_cnt_q + PCW'(1);
                                state_d    = SETUP;
                            end
                        end else if (cur_q.rwb) begin
                            rdata_d       = rbuf_q;
                            rdata_valid_d = 1'b1;
                            state_d       = IDLE;
                        end else if (pollen_q) begin
                            polling_d  = 1'b1;
                            poll_cnt_d = '0;
                            state_d    = SETUP;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        err_d = flush_i ? 1'b0 : (err_q | err_set);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            presc_q       <= '0;
            cnt_q         <= '0;
            nib_q         <= 1'b0;
            polling_q     <= 1'b0;
            pollen_q      <= 1'b0;
            poll_cnt_q    <= '0;
            rbuf_q        <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            presc_q       <= presc_d;
            cnt_q         <= cnt_d;
            nib_q         <= nib_d;
            polling_q     <= polling_d;
            pollen_q      <= pollen_d;
            poll_cnt_q    <= poll_cnt_d;
            rbuf_q        <= rbuf_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            ovf_q         <= ovf_d;
            err_q         <= err_d;
        end
    end

    assign instr_ready_o = !fifo_full;
    assign busy_o        = active;
    assign rs_o          = active && rs_act;
    assign rwb_o         = active && rwb_act;
    assign data_oe_o     = active && !rwb_act;
    assign data_out_o    = dout8[BUS_WIDTH-1:0];
    assign e_o           = (state_q == EHIGH) ? emask : '0;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign ovf_o         = ovf_q;
    assign err_o         = err_q;
endmodule
